// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller slice:
// command opcodes, controller states and the integration count default.
package run_controller_pkg;

    localparam int unsigned CMD_NOOP        = 0;
    localparam int unsigned CMD_START       = 1;
    localparam int unsigned CMD_STOP        = 2;
    localparam int unsigned CMD_SET_FRAMES  = 3;
    localparam int unsigned CMD_CLEAR_ERROR = 4;

    localparam int unsigned DEF_COUNT = 5000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_DRAINING
    } state_t;

endpackage

// File: rtl/run_controller_if.sv
// Command bus from the USB command path into the run controller.
// The host side drives it; the controller only listens.
interface run_controller_if #(
    parameter int CMD_W = 16
) ();

    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_word;

    modport master (output cmd_valid, output cmd_word);
    modport slave  (input  cmd_valid, input  cmd_word);

endinterface

// File: rtl/run_controller_command_decoder.sv
// Splits a command word into opcode and value and
// produces one-hot strobes qualified by cmd_valid.
module command_decoder
    import run_controller_pkg::*;
#(
    parameter int CMD_W = 16,
    parameter int OP_W  = 3,
    parameter int VAL_W = CMD_W - OP_W
) (
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_word,
    output logic [VAL_W-1:0] value,
    output logic             is_start,
    output logic             is_stop,
    output logic             is_set_frames,
    output logic             is_clear,
    output logic             is_illegal
);

    logic [OP_W-1:0] op;

    assign op    = cmd_word[CMD_W-1 -: OP_W];
    assign value = cmd_word[VAL_W-1:0];

    assign is_start      = cmd_valid && (op == OP_W'(CMD_START));
    assign is_stop       = cmd_valid && (op == OP_W'(CMD_STOP));
    assign is_set_frames = cmd_valid && (op == OP_W'(CMD_SET_FRAMES));
    assign is_clear      = cmd_valid && (op == OP_W'(CMD_CLEAR_ERROR));
    assign is_illegal    = cmd_valid && (op > OP_W'(CMD_CLEAR_ERROR));

endmodule

// File: rtl/run_controller.sv
// Run/command controller: owns the running flag, integration count,
// frame-limited runs with auto-stop and graceful (draining) stop.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int CMD_W         = 16,
    parameter int OP_W          = 3,
    parameter int COUNT_W       = 32,
    parameter int SCALE_SHIFT   = 2,
    parameter int FRAME_W       = 16,
    parameter int DEFAULT_COUNT = DEF_COUNT
) (
    input  logic               clk_in,
    input  logic               reset,
    run_controller_if.slave    cmd,
    input  logic               frame_done,
    output logic               running,
    output logic [COUNT_W-1:0] integration_clock_count,
    output logic [FRAME_W-1:0] frame_count,
    output logic               run_start,
    output logic               run_stop,
    output logic               cmd_error,
    output logic               is_on,
    output logic               is_off
);

    localparam int VAL_W = CMD_W - OP_W;
    localparam int TW    = (VAL_W < FRAME_W) ? VAL_W : FRAME_W;

    logic [VAL_W-1:0] value;
    logic is_start, is_stop, is_set_frames, is_clear, is_illegal;

    command_decoder #(
        .CMD_W (CMD_W),
        .OP_W  (OP_W),
        .VAL_W (VAL_W)
    ) u_dec (
        .cmd_valid     (cmd.cmd_valid),
        .cmd_word      (cmd.cmd_word),
        .value         (value),
        .is_start      (is_start),
        .is_stop       (is_stop),
        .is_set_frames (is_set_frames),
        .is_clear      (is_clear),
        .is_illegal    (is_illegal)
    );

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] icc_q, icc_d;
    logic [FRAME_W-1:0] fc_q, fc_d, fc_inc;
    logic [FRAME_W-1:0] tgt_q, tgt_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;

    assign fc_inc = (&fc_q) ? fc_q : fc_q + FRAME_W'(1);

    // State register and all registered outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            icc_q   <= COUNT_W'(DEFAULT_COUNT);
            fc_q    <= '0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            icc_q   <= icc_d;
            fc_q    <= fc_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    // Next state, counters, error flag and start/stop pulses
    always_comb begin
        state_d = state_q;
        icc_d   = icc_q;
        fc_d    = fc_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        start_d = 1'b0;
        stop_d  = 1'b0;

        if (is_illegal) err_d = 1'b0 | 1'b1;
        if (is_clear)   err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    if (value != '0) begin
                        icc_d   = COUNT_W'(value) << SCALE_SHIFT;
                        fc_d    = '0;
                        state_d = ST_RUNNING;
                        start_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (is_set_frames) tgt_d = FRAME_W'(value[TW-1:0]);
            end
            ST_RUNNING: begin
                if (is_start || is_set_frames) err_d = 1'b1;
                if (frame_done) begin
                    fc_d = fc_inc;
                    if (is_stop || (tgt_q != '0 && fc_inc == tgt_q)) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b1;
                    end
                end else if (is_stop) begin
                    state_d = ST_DRAINING;
                end
            end
            ST_DRAINING: begin
                if (is_start || is_set_frames) err_d = 1'b1;
                if (frame_done) begin
                    fc_d    = fc_inc;
                    state_d = ST_IDLE;
                    stop_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign running                 = (state_q != ST_IDLE);
    assign is_on                   = running;
    assign is_off                  = ~running;
    assign integration_clock_count = icc_q;
    assign frame_count             = fc_q;
    assign run_start               = start_q;
    assign run_stop                = stop_q;
    assign cmd_error               = err_q;

endmodule

// File: doc/run_controller.md
# run_controller

Parametrised run/command controller between the USB command path and the readout controller. It decodes command words delivered with a valid strobe and owns the `running` flag and the integration clock count. It adds two things to the bare start/stop flag: frame-limited runs with auto-stop, and a graceful stop that lets the current frame finish. Illegal or out-of-state commands are rejected and raise a sticky error.

## Interface
Parameters:
- `CMD_W`, 16, command word width.
- `OP_W`, 3, opcode field width, taken from `cmd_word[CMD_W-1 -: OP_W]`. Must be ≥3.
- `VAL_W = CMD_W-OP_W`, derived, value field width, `cmd_word[VAL_W-1:0]`.
- `COUNT_W`, 32, integration count width. Must be ≥ VAL_W+SCALE_SHIFT.
- `SCALE_SHIFT`, 2, left shift applied to the START value.
- `FRAME_W`, 16, width of the frame target and frame counter.
- `DEFAULT_COUNT`, 5000, reset value of the integration count.

Ports (one clock; reset is asynchronous and active-high):
- `clk_in`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  one-cycle strobe; `cmd_word` is valid this cycle
- `cmd_word`  in  CMD_W  opcode and value
- `frame_done`  in  1  one-cycle pulse from the readout controller at the end of a frame
- `running`  out  1  AFE readout enabled
- `integration_clock_count`  out  COUNT_W  integration length in clk_in cycles
- `frame_count`  out  FRAME_W  frames completed in the current/last run, saturating
- `run_start`  out  1  one-cycle pulse when a run begins
- `run_stop`  out  1  one-cycle pulse when a run ends
- `cmd_error`  out  1  sticky rejected-command flag
- `is_on`, `is_off`  out  1  LED drives: `running` and its inverse

## Operation
- Opcodes:
  - NOOP=0
  - START=1
  - STOP=2
  - SET_FRAMES=3
  - CLEAR_ERROR=4
  - codes 5 and above are illegal: set `cmd_error`, no other effect.
- States: IDLE, RUNNING, DRAINING. `running` is 1 in RUNNING and DRAINING.
- IDLE:
  - START with value≠0: `integration_clock_count` ← zero-extended value<<SCALE_SHIFT; `frame_count` ← 0; go to RUNNING; pulse `run_start`.
  - START with value=0: `cmd_error`, stay in IDLE.
  - SET_FRAMES: `frame_target` ← value[FRAME_W-1:0], zero-extended if VAL_W<FRAME_W. Target 0 means unlimited.
  - STOP: no-op, no error.
- RUNNING:
  - `frame_done` increments `frame_count`, saturating at all-ones.
  - If `frame_target`≠0 and the incremented count equals `frame_target`: go to IDLE, pulse `run_stop`.
  - STOP: go to DRAINING. If `frame_done` arrives in the same cycle, count the frame and go directly to IDLE with `run_stop`.
  - START or SET_FRAMES: `cmd_error`, ignored.
- DRAINING:
  - `frame_done` counts the frame, then go to IDLE and pulse `run_stop`.
  - STOP: ignored, no error.
  - START or SET_FRAMES: `cmd_error`.
- CLEAR_ERROR clears `cmd_error` in any state. An error raised in the same cycle cannot occur, because only one command is accepted per cycle.
- NOOP: no effect in any state.
- `frame_done` in IDLE is ignored.
- `frame_target` persists across runs. Reset sets it to 0.

## Timing
- A command is sampled on the rising edge where `cmd_valid`=1. All outputs are registered and change on that same edge, so they are visible the following cycle (1-cycle latency).
- `run_start` is high for exactly the first cycle `running`=1.
- `run_stop` is high for exactly the first cycle `running`=0 after a run.
- The `frame_count` update and the auto-stop take effect on the same edge that samples `frame_done`.
- Reset values, applied asynchronously:
  - state IDLE
  - `running`=0, `is_on`=0, `is_off`=1
  - `integration_clock_count`=DEFAULT_COUNT
  - `frame_count`=0, `frame_target`=0
  - `run_start`=0, `run_stop`=0
  - `cmd_error`=0
- Reset asserted mid-run forces IDLE immediately, without a `run_stop` pulse.
- Back-to-back commands on consecutive cycles are all honoured. No backpressure.

## Structure
- A shared package holds:
  - the opcode constants (`CMD_NOOP`, `CMD_START`, `CMD_STOP`, `CMD_SET_FRAMES`, `CMD_CLEAR_ERROR`)
  - the state enum
  - the DEFAULT_COUNT default
- USB controller and host-facing code import the opcode constants from that package.
- One sub-module is natural: `command_decoder`. It is purely combinational. It splits `cmd_word` into op and value and emits one-hot `is_start`/`is_stop`/`is_set_frames`/`is_clear`/`is_illegal`, qualified by `cmd_valid`.
- The state machine, counters and pulse registers stay in `run_controller`.

## Test plan
- Reset checks:
  - After reset: `integration_clock_count`=5000, `running`=0, `is_off`=1.
  - Assert reset mid-run: `running`=0 immediately and no `run_stop` pulse.
- START value 100 in IDLE → next cycle `running`=1, `integration_clock_count`=400, `run_start` high for 1 cycle. START value 0 → `cmd_error`=1, `running` stays 0.
- SET_FRAMES 3, START 10, then 3 `frame_done` pulses → `frame_count`=3 and `running` drops on the edge of the third pulse with a single `run_stop`. A 4th `frame_done` leaves `frame_count` at 3.
- Unlimited run, then STOP:
  - Stay in DRAINING with `running`=1 until `frame_done`, then go to IDLE.
  - Repeat with STOP and `frame_done` in the same cycle → IDLE after one edge, `frame_count` incremented.
- START while RUNNING and opcode 7 in IDLE → `cmd_error`=1, count and state unchanged. CLEAR_ERROR → `cmd_error`=0. STOP in IDLE → no error.
